gen_scheduler: RTL and testbench
================================

// Module: gen_scheduler
// PURPOSE
//  Shares one serial bit generator (1-bit OUT per clock) between NUM_REQ
//  requesters. Arbitrates round-robin, steps the generator exactly WORD_W
//  times per grant, packs the bits into a word and hands the word to the
//  granted requester over a valid/ready handshake. Sits between the
//  generator instance and its consumers; it is the generator's only stepper.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WORD_W   8  bits collected per grant (>=2); counter width $clog2(WORD_W)
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high reset
//  gen_out     in   1        generator OUT bit, consumed on cycles gen_step=1
//  gen_step    out  1        advance generator this cycle
//  req         in   NUM_REQ  request lines, one per requester
//  gnt         out  NUM_REQ  one-hot grant, registered
//  word        out  WORD_W   collected word, MSB = first bit collected
//  word_valid  out  1        word available to granted requester
//  word_ready  in   1        granted requester accepts word
//  busy        out  1        high in COLLECT and DELIVER
// BEHAVIOUR
//  Reset (async): state=IDLE, gnt=0, word=0, word_valid=0, gen_step=0,
//   busy=0, cnt=0, last=NUM_REQ-1 (so requester 0 wins first).
//  FSM states IDLE, COLLECT, DELIVER:
//  - IDLE: if |req at edge, winner = first set req scanning from
//    (last+1) mod NUM_REQ upward with wrap; gnt<=onehot(winner),
//    last<=winner, cnt<=0, ->COLLECT. No req: stay, outputs 0.
//  - COLLECT: gen_step=1 (decoded from state, same cycle). Each edge:
//    word<={word[WORD_W-2:0],gen_out}, cnt<=cnt+1. On the edge where
//    cnt==WORD_W-1: last bit shifted, word_valid<=1, ->DELIVER.
//    word_valid rises exactly WORD_W edges after gnt rises.
//  - DELIVER: gen_step=0; word, gnt, word_valid held stable. On edge with
//    word_valid&&word_ready: word_valid<=0, gnt<=0, ->IDLE.
//  Minimum one IDLE cycle between consecutive grants; gnt never changes
//   while busy.
//  req is sampled only in IDLE; a granted requester dropping req during
//   COLLECT/DELIVER does not abort; the transaction completes normally.
//  word_ready ignored outside DELIVER.
//  Generator is stepped exactly WORD_W times per grant, never otherwise;
//   unconsumed generator state is preserved across idle time.
//  Reset mid-operation: immediate return to reset values; partial word
//   discarded; round-robin pointer restarts at requester 0.
//  gnt is one-hot or zero at all times.
// TESTING
//  1 req=4'b0100 held, gen_out seq 1,0,1,1,0,0,1,0, word_ready=1 ->
//    gnt=4'b0100, word=8'hB2, word_valid 1 cycle, exactly 8 gen_step cycles.
//  2 req=4'b1111 held, word_ready=1 -> grants 0,1,2,3,0,1 in order,
//    one IDLE cycle between each.
//  3 word_ready=0 for 5 cycles in DELIVER -> word, gnt, word_valid stable,
//    gen_step=0 throughout; handshake on 6th cycle returns to IDLE.
//  4 req[1] deasserted after 3 COLLECT cycles -> word still delivered to
//    requester 1 after remaining 5 bits.
//  5 reset pulsed 2ns during COLLECT (cnt=4) -> gnt/word/valid/step=0
//    immediately; next req=4'b1010 grants requester 1.
//  6 After test 2 last=1, req=4'b0011 -> gnt=4'b0001 (wraps past 2,3).

Source files
------------

// File: rtl/gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gen_scheduler
// Purpose  : Round-robin sharing of one serial bit generator; collects WORD_W
//            bits per grant and delivers the packed word over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module gen_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen_out,
  output logic               gen_step,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WORD_W-1:0]  word,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               busy
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      last_q, last_d;

  logic               win_found;
  logic [LW-1:0]      win_idx;
  logic [LW-1:0]      try_idx;

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    try_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      try_idx = LW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && req[try_idx]) begin
        win_found = 1'b1;
        win_idx   = try_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        word_d = {word_q[WORD_W-2:0], gen_out};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WORD_W - 1)) begin
          word_valid_d = 1'b1;
          state_d      = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          gnt_d        = '0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        gnt_d        = '0;
        word_valid_d = 1'b0;
      end
    endcase
  end

  // Reset also rewinds the pointer so requester 0 is favoured next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      cnt_q        <= '0;
      last_q       <= LW'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  assign gen_step   = (state_q == S_COLLECT);
  assign busy       = (state_q != S_IDLE);
  assign gnt        = gnt_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_scheduler
// Purpose  : Directed and randomized self-checking bench for gen_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_scheduler;

  logic       clk;
  logic       reset;
  logic       gen_out;
  logic       gen_step;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int model_last = 3;
  logic [3:0] obs_gnt;
  logic [7:0] obs_word;

  gen_scheduler #(.NUM_REQ(4), .WORD_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_out    (gen_out),
    .gen_step   (gen_step),
    .req        (req),
    .gnt        (gnt),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester after the previous winner, wrapping.
  function automatic int pick(input logic [3:0] r);
    int idx;
    for (int i = 1; i <= 4; i++) begin
      idx = (model_last + i) % 4;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   32'(gnt),        32'h0);
    check({tag, "_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_step"},  32'(gen_step),   32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
  endtask

  task automatic idle_cycles(input int n);
    req = 4'b0000;
    for (int i = 0; i < n; i++) begin
      word_ready = 1'($urandom);
      gen_out    = 1'($urandom);
      @(negedge clk);
      check_idle("idle");
    end
    word_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    req = 4'b0000;
    #1 reset = 1'b1;
    #1;
    check_idle("rst");
    check("rst_word", 32'(word), 32'h0);
    #1 reset = 1'b0;
    model_last = 3;
    @(negedge clk);
    check_idle("post_rst");
  endtask

  // Called on a negedge with the DUT idle; req set here is granted next edge.
  task automatic do_txn(input logic [3:0] r, input logic [7:0] bits,
                        input int stall, input int drop_at, input int reset_at);
    int w;
    logic [3:0] eg;
    req = r;
    w   = pick(r);
    eg  = 4'b0001 << w;
    model_last = w;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 0) obs_gnt = gnt;
      check("col_gnt",   32'(gnt),        32'(eg));
      check("col_step",  32'(gen_step),   32'h1);
      check("col_valid", 32'(word_valid), 32'h0);
      check("col_busy",  32'(busy),       32'h1);
      if (b == reset_at) begin
        pulse_reset();
        return;
      end
      if (b == drop_at) req = 4'b0000;
      gen_out    = bits[7-b];
      word_ready = 1'($urandom);
    end
    word_ready = 1'b0;
    @(negedge clk);
    obs_word = word;
    check("dlv_valid", 32'(word_valid), 32'h1);
    check("dlv_word",  32'(word),       32'(bits));
    check("dlv_gnt",   32'(gnt),        32'(eg));
    check("dlv_step",  32'(gen_step),   32'h0);
    for (int s = 0; s < stall; s++) begin
      gen_out = 1'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(word_valid), 32'h1);
      check("stall_word",  32'(word),       32'(bits));
      check("stall_gnt",   32'(gnt),        32'(eg));
      check("stall_step",  32'(gen_step),   32'h0);
      check("stall_busy",  32'(busy),       32'h1);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check_idle("done");
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    reset      = 1'b1;
    req        = 4'b0000;
    gen_out    = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_word", 32'(word), 32'h0);
    reset = 1'b0;
    idle_cycles(3);

    // Single requester, known bit pattern
    do_txn(4'b0100, 8'b1011_0010, 0, -1, -1);
    check("t1_gnt",  32'(obs_gnt),  32'h4);
    check("t1_word", 32'(obs_word), 32'hB2);

    // Everyone requesting: strict rotation from requester 0
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      do_txn(4'b1111, 8'($urandom), 0, -1, -1);
      check("t2_order", 32'(obs_gnt), 32'(4'b0001 << order[k]));
    end

    // Pointer at 1: requests 0 and 1 wrap around to requester 0
    do_txn(4'b0011, 8'($urandom), 0, -1, -1);
    check("t6_wrap", 32'(obs_gnt), 32'h1);

    // Consumer stalls five cycles
    do_txn(4'b1000, 8'h5C, 5, -1, -1);
    check("t3_word", 32'(obs_word), 32'h5C);

    // Granted requester drops its request mid-collection
    idle_cycles(1);
    do_txn(4'b0010, 8'hE7, 1, 3, -1);
    check("t4_gnt",  32'(obs_gnt),  32'h2);
    check("t4_word", 32'(obs_word), 32'hE7);

    // Reset at cnt=4, then 1010 must go to requester 1
    do_txn(4'b0001, 8'($urandom), 0, -1, 4);
    do_txn(4'b1010, 8'h3D, 0, -1, -1);
    check("t5_gnt",  32'(obs_gnt),  32'h2);
    check("t5_word", 32'(obs_word), 32'h3D);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (r == 4'b0000) idle_cycles(int'($urandom_range(1, 3)));
      else do_txn(r, 8'($urandom), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
